// File: rtl/recir_arbiter.sv
// Round-robin burst scheduler draining four recirculation FIFOs onto one
// registered symbol stream, with downstream back-pressure and IDLE fill.
module recir_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter logic [7:0]  IDLE_SYM  = 8'h7C
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] fifo_empty,
  input  logic [8:0] fifo_data0,
  input  logic [8:0] fifo_data1,
  input  logic [8:0] fifo_data2,
  input  logic [8:0] fifo_data3,
  input  logic [3:0] port_en,
  input  logic       out_ready,
  output logic [3:0] fifo_pop,
  output logic [1:0] grant,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_idle
);

  typedef enum logic {ARB, SERVE} state_t;

  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [3:0]      pop;
  logic [1:0]      scan_idx;
  logic [3:0]      eligible;
  logic            load_en;
  logic [3:0][8:0] head_all;
  logic [8:0]      head;

  assign head_all = {fifo_data3, fifo_data2, fifo_data1, fifo_data0};
  assign head     = head_all[grant_q];
  assign eligible = port_en & ~fifo_empty;
  assign load_en  = ~out_valid_q | out_ready;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pop         = 4'b0000;
    scan_idx    = 2'd0;
    // A stalled output freezes the whole scheduler, not just the data path.
    if (load_en) begin
      out_valid_d = 1'b0;
      out_data_d  = IDLE_SYM;
      case (state_q)
        ARB: begin
          if (|eligible) begin
            // Scan from farthest to nearest so the nearest eligible index wins.
            for (int k = 4; k >= 1; k--) begin
              scan_idx = grant_q + 2'(k);
              if (eligible[scan_idx]) grant_d = scan_idx;
            end
            burst_cnt_d = 4'd0;
            state_d     = SERVE;
          end
        end
        SERVE: begin
          if (eligible[grant_q]) begin
            pop[grant_q] = 1'b1;
            burst_cnt_d  = burst_cnt_q + 4'd1;
            if (head[8]) begin
              out_valid_d = 1'b1;
              out_data_d  = head[7:0];
            end
            if (burst_cnt_q == LAST) state_d = ARB;
          end else begin
            state_d = ARB;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ARB;
      grant_q     <= 2'd3;
      burst_cnt_q <= 4'd0;
      out_data_q  <= IDLE_SYM;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fifo_pop  = reset ? 4'b0000 : pop;
  assign grant     = grant_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_idle  = ~out_valid_q;

endmodule

// File: tb/tb_recir_arbiter.sv
// Scoreboard bench for recir_arbiter: FIFO models feed the DUT, expected
// symbols are queued at load time and popped by a monitor on each accepted beat.
module tb_recir_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] fifo_empty;
  logic [8:0] fifo_data0, fifo_data1, fifo_data2, fifo_data3;
  logic [3:0] port_en;
  logic       out_ready;
  logic [3:0] fifo_pop;
  logic [1:0] grant;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_idle;

  recir_arbiter dut (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_data0(fifo_data0), .fifo_data1(fifo_data1),
    .fifo_data2(fifo_data2), .fifo_data3(fifo_data3),
    .port_en(port_en), .out_ready(out_ready), .fifo_pop(fifo_pop),
    .grant(grant), .out_data(out_data), .out_valid(out_valid), .out_idle(out_idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed { logic [7:0] d; logic [1:0] g; } exp_t;

  exp_t       exp_q[$];
  logic [8:0] fq[4][$];
  int         checks   = 0;
  int         failures = 0;

  logic       s_valid;
  logic [7:0] s_data;
  logic [3:0] s_pop;
  logic [1:0] s_grant;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) fifo_empty[i] = (fq[i].size() == 0);
    fifo_data0 = (fq[0].size() != 0) ? fq[0][0] : 9'h000;
    fifo_data1 = (fq[1].size() != 0) ? fq[1][0] : 9'h000;
    fifo_data2 = (fq[2].size() != 0) ? fq[2][0] : 9'h000;
    fifo_data3 = (fq[3].size() != 0) ? fq[3][0] : 9'h000;
  endtask

  // Samples the current cycle's outputs, then advances one edge and applies pops.
  task automatic step();
    @(negedge clock);
    s_valid = out_valid;
    s_data  = out_data;
    s_pop   = fifo_pop;
    s_grant = grant;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++)
      if (s_pop[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    refresh();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    chk(name, exp_q.size(), 0);
    repeat (4) step();
  endtask

  task automatic load(input int f, input logic [8:0] e);
    fq[f].push_back(e);
    if (e[8]) exp_q.push_back('{d: e[7:0], g: 2'(f)});
  endtask

  always @(negedge clock) begin
    if (reset) begin
      chk("pop_in_reset", fifo_pop, 4'b0000);
    end else begin
      chk("idle_inv", out_idle, !out_valid);
      if (!out_valid) chk("idle_sym", out_data, 8'h7C);
      chk("pop_legal", fifo_pop & ~(port_en & ~fifo_empty), 4'b0000);
      chk("pop_onehot", ($countones(fifo_pop) > 1), 1'b0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_symbol actual=0x%0h grant=%0d expected=none", out_data, grant);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sym_data", out_data, e.d);
          chk("sym_grant", grant, e.g);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  vpat;
    logic [44:0] bpat, bexp;
    logic [53:0] spat;
    int          npop;

    reset     = 1'b1;
    out_ready = 1'b1;
    port_en   = 4'hF;
    refresh();
    repeat (3) step();
    reset = 1'b0;

    // Idle after reset with nothing queued.
    for (int k = 0; k < 20; k++) begin
      step();
      chk("reset_idle", {s_valid, s_data, s_pop}, {1'b0, 8'h7C, 4'b0000});
      if (k == 0) chk("reset_grant", s_grant, 2'd3);
    end

    // FIFO1 with six entries: burst of 4, one ARB gap, burst of 2.
    for (int j = 0; j < 6; j++) load(1, {1'b1, 8'hA0 + 8'(j)});
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      vpat[k] = s_valid;
      if (k >= 1) chk("f1_grant", s_grant, 2'd1);
    end
    chk("f1_valid_pattern", vpat, 10'b0110111100);
    drain("f1_drain", 20);

    // All four FIFOs loaded: round-robin 0,1,2,3,0,1,2,3 with bursts of 4.
    do_reset(2);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++) fq[i].push_back({1'b1, 8'(8'h80 + i * 16 + j)});
    for (int b = 0; b < 8; b++)
      for (int m = 0; m < 4; m++)
        exp_q.push_back('{d: 8'(8'h80 + (b % 4) * 16 + (b / 4) * 4 + m), g: 2'(b % 4)});
    step();
    for (int k = 0; k < 45; k++) begin
      step();
      bpat[k] = s_valid;
      bexp[k] = (k >= 2) && (k - 2 < 40) && (((k - 2) % 5) != 4);
    end
    chk("rr_valid_pattern", bpat, bexp);
    drain("rr_drain", 20);

    // Back-pressure for three cycles mid-burst.
    do_reset(2);
    for (int j = 0; j < 4; j++) load(0, {1'b1, 8'h51 + 8'(j)});
    step();
    repeat (3) step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold", {s_valid, s_data, s_pop}, {1'b1, 8'h52, 4'b0000});
    end
    out_ready = 1'b1;
    drain("bp_drain", 20);

    // Invalid entry in the middle is popped but not forwarded.
    do_reset(2);
    load(2, {1'b1, 8'h11});
    load(2, {1'b0, 8'h22});
    load(2, {1'b1, 8'h33});
    step();
    npop = 0;
    spat = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      spat = {spat[44:0], s_valid, s_data};
      npop += $countones(s_pop);
    end
    chk("discard_seq", spat, {9'h07C, 9'h07C, 9'h111, 9'h07C, 9'h133, 9'h07C});
    chk("discard_pops", npop, 3);
    drain("discard_drain", 20);

    // Reset mid-burst on FIFO3, FIFO0 disabled while holding data.
    do_reset(2);
    port_en = 4'b1110;
    load(0, {1'b0, 8'hE0});
    load(0, {1'b0, 8'hE1});
    load(0, {1'b0, 8'hE2});
    for (int j = 0; j < 6; j++) fq[3].push_back({1'b1, 8'h30 + 8'(j)});
    exp_q.push_back('{d: 8'h30, g: 2'd3});
    step();
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("midrst_pop", s_pop, 4'b0000);
    load(1, {1'b1, 8'h71});
    load(1, {1'b1, 8'h72});
    for (int j = 2; j < 6; j++) exp_q.push_back('{d: 8'h30 + 8'(j), g: 2'd3});
    step();
    chk("midrst_state", {s_valid, s_data, s_grant, s_pop}, {1'b1 ^ 1'b1, 8'h7C, 2'd3, 4'b0000});
    reset = 1'b0;
    step();
    step();
    chk("post_rst_grant", s_grant, 2'd1);
    drain("midrst_drain", 30);
    chk("ff0_untouched", fq[0].size(), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
